multi_input_counter: RTL
========================

# multi_input_counter

Parametrised multi-channel gated edge counter for the counter project. It counts synchronised rising edges on N_CH asynchronous inputs during a shared gate window and provides live counts. At the end of each window it latches a snapshot with a one-cycle valid strobe. Per channel it supports wrap or saturate overflow behaviour with sticky overflow flags, so the readout logic can sample complete, consistent gate frames.

## Interface
- N_CH, 4, number of input channels (1..32)
- CNT_W, 32, counter width per channel (2..32)
- SYNC_STAGES, 2, synchroniser flops per input (>=2)
- SATURATE, 0, 0 = wrap at 2^CNT_W, 1 = hold at 2^CNT_W-1
- i_clk  input  1  clock
- i_reset  input  1  synchronous, active-high reset
- i_signal  input  N_CH  asynchronous pulse inputs, one bit per channel
- i_gate  input  1  counting window, synchronous to i_clk
- o_count  output  N_CH*CNT_W  live counts; channel c occupies bits [c*CNT_W +: CNT_W]
- o_latched  output  N_CH*CNT_W  snapshot of counts at the end of the last window
- o_overflow  output  N_CH  live sticky overflow flags
- o_latched_ovf  output  N_CH  overflow flags captured with o_latched
- o_valid  output  1  one-cycle strobe, high when o_latched has just been updated
- o_frame  output  16  number of completed windows, wraps at 2^16
- o_running  output  1  high while state is RUN

## Operation
- **Input path, per channel**
  - i_signal passes through a SYNC_STAGES flop chain, then one delay flop.
  - edge_p[c] = sync_last & ~delay, giving a one-cycle pulse per rising edge.
  - A high level lasting many cycles produces exactly one pulse.
- **State machine, two states**
  - IDLE (reset state): counts hold their values; no counting.
  - IDLE -> RUN when i_gate=1 (start cycle). In the start cycle:
    - counts are cleared to 0, or set to 1 for any channel with edge_p in that cycle;
    - o_overflow is cleared.
  - RUN: count[c] increments on each cycle where i_gate=1 and edge_p[c]=1.
  - RUN -> IDLE when i_gate=0 (stop cycle). In the stop cycle:
    - an edge_p is not counted;
    - o_latched <= counts and o_latched_ovf <= o_overflow;
    - o_valid goes high for exactly the next cycle;
    - o_frame increments.
- **Overflow**, increment requested while count = 2^CNT_W-1:
  - SATURATE=0: count becomes 0 and o_overflow[c] sets;
  - SATURATE=1: count holds and o_overflow[c] sets.
  - Flags stay set until the next start cycle or reset.
- **Channels** are independent. Simultaneous edges on all channels in one cycle each count once.
- **Reset** (i_reset=1) takes priority over everything and clears all outputs:
  - sync chains, delay flops, counts, o_latched, o_overflow, o_latched_ovf, o_valid and o_frame go to 0;
  - state goes to IDLE, so o_running=0.
  - Reset mid-window discards the window: no o_valid and no latch.
  - If i_gate=1 on the first cycle after reset, that cycle is a start cycle.

## Timing
- **Edge latency:** an i_signal rise first sampled at edge k updates o_count at edge k+SYNC_STAGES (k+2 by default).
- **Gate:** sampled directly, with no synchroniser.
  - The start cycle is the first clock with i_gate=1 in IDLE.
  - o_running is registered and goes high one cycle after the start cycle.
- **End of window:** o_latched, o_latched_ovf and o_frame update at the edge ending the stop cycle; o_valid is high during the following cycle only.
- **Minimum windows:**
  - a one-cycle gate pulse is a valid window;
  - IDLE lasts at least one cycle between windows, so back-to-back gates need i_gate low for at least one cycle.
- **Input pulses:** must be high and low for at least SYNC_STAGES+1 clock periods each to be counted reliably.
- **Outputs:** all registered; no combinational path from any input to any output.

## Test plan
- **Reset:** drive toggling i_signal during reset with i_gate=0 -> all outputs 0, o_running=0, no o_valid.
- **Basic count:** i_gate high 100 cycles, 10 pulses on ch0 and 3 on ch2, each 4 cycles high and 4 low -> o_latched ch0=10, ch2=3, others 0; o_valid high 1 cycle after gate fall; o_frame=1.
- **Gate boundaries:**
  - an edge_p coinciding with the start cycle is counted;
  - an edge_p coinciding with the stop cycle is not counted;
  - a held-high input yields count 1.
- **Overflow, CNT_W=4:** 17 pulses in one window.
  - SATURATE=0 -> latched 1, o_latched_ovf=1.
  - SATURATE=1 -> latched 15, o_latched_ovf=1.
  - Next window with 2 pulses -> latched 2, ovf=0.
- **Reset mid-window:** assert i_reset after 5 counted pulses -> counts 0, no o_valid, o_frame unchanged at 0.
  - i_gate still high after release -> new window starts, and its counts start from 0.
- **Back-to-back windows:** gate 20 cycles high, 1 low, 20 high, with 2 then 4 pulses.
  - Two o_valid strobes, latched values 2 then 4, o_frame=2.
  - Live o_count holds 4 after the second window.

Source files
------------

// File: rtl/multi_input_counter.sv
// Gated multi-channel rising-edge counter with per-window snapshot.
// Wrap or saturate overflow per channel, sticky overflow flags.
module multi_input_counter #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [N_CH-1:0]       i_signal,
  input  logic                  i_gate,
  output logic [N_CH*CNT_W-1:0] o_count,
  output logic [N_CH*CNT_W-1:0] o_latched,
  output logic [N_CH-1:0]       o_overflow,
  output logic [N_CH-1:0]       o_latched_ovf,
  output logic                  o_valid,
  output logic [15:0]           o_frame,
  output logic                  o_running
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [N_CH-1:0] sync [SYNC_STAGES];
  logic [N_CH-1:0] dly;
  logic [N_CH-1:0] edge_p;
  logic [N_CH-1:0] wrap;
  logic [N_CH*CNT_W-1:0] inc;
  logic [N_CH*CNT_W-1:0] first;
  state_t state;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync[s] <= '0;
      end
      dly <= '0;
    end else begin
      sync[0] <= i_signal;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync[s] <= sync[s-1];
      end
      dly <= sync[SYNC_STAGES-1];
    end
  end

  assign edge_p = sync[SYNC_STAGES-1] & ~dly;

  // Next counts for a running window and for a start cycle.
  always_comb begin
    inc   = o_count;
    first = '0;
    wrap  = '0;
    for (int c = 0; c < N_CH; c++) begin
      first[c*CNT_W +: CNT_W] = CNT_W'(edge_p[c]);
      if (edge_p[c]) begin
        if (o_count[c*CNT_W +: CNT_W] == MAX) begin
          wrap[c] = 1'b1;
          if (SATURATE == 0) begin
            inc[c*CNT_W +: CNT_W] = '0;
          end
        end else begin
          inc[c*CNT_W +: CNT_W] =
            o_count[c*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      o_running     <= 1'b0;
      o_count       <= '0;
      o_latched     <= '0;
      o_overflow    <= '0;
      o_latched_ovf <= '0;
      o_valid       <= 1'b0;
      o_frame       <= '0;
    end else begin
      o_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_gate) begin
            state      <= RUN;
            o_running  <= 1'b1;
            o_count    <= first;
            o_overflow <= '0;
          end
        end
        RUN: begin
          if (i_gate) begin
            o_count    <= inc;
            o_overflow <= o_overflow | wrap;
          end else begin
            state         <= IDLE;
            o_running     <= 1'b0;
            o_latched     <= o_count;
            o_latched_ovf <= o_overflow;
            o_valid       <= 1'b1;
            o_frame       <= o_frame + 16'd1;
          end
        end
      endcase
    end
  end

endmodule
